subsistema_multiplicacion: RTL
==============================

SUBSISTEMA_MULTIPLICACION -- requirements
Module: subsistema_multiplicacion

Interface
REQ-001 The block SHALL have the port reloj, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reinicio, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port operandoA, input, 4 bits: unsigned multiplicand from the operand-reading stage.
REQ-004 The block SHALL have the port operandoB, input, 4 bits: unsigned multiplier from the operand-reading stage.
REQ-005 The block SHALL have the port banderaValida, input, 1 bit: operands valid, level-held by the reading stage.
REQ-006 The block SHALL have the port producto, output, 8 bits: registered unsigned product.
REQ-007 The block SHALL have the port banderaListo, output, 1 bit: the result on producto is complete.
REQ-008 The block SHALL have the port ocupado, output, 1 bit: a calculation is in progress.
REQ-009 The block SHALL have the port banderaCero, output, 1 bit: the completed product equals 0.

Function
REQ-010 The block SHALL implement the states REPOSO, CALCULO and LISTO, plus a 2-bit iteration counter cuenta.
REQ-011 In REPOSO with banderaValida=1 at an edge, the block SHALL register operandoA and operandoB internally, clear the 8-bit accumulator, set cuenta=0, and move to CALCULO.
REQ-012 In REPOSO with banderaValida=0, the block SHALL stay in REPOSO with all registers held.
REQ-013 In CALCULO, the block SHALL do one shift-add step per edge: if bit cuenta of the registered B is 1, it adds (registered A << cuenta) to the accumulator, then increments cuenta.
REQ-014 The block SHALL keep the accumulator at 8 bits; the maximum 15x15=225 never overflows, and no carry out is produced.
REQ-015 On the edge that executes the step with cuenta=3, the block SHALL load producto with the final accumulator value, set banderaListo=1, and move to LISTO.
REQ-016 Latency SHALL be exactly 4 edges after the capture edge: capture at edge N, banderaListo=1 visible after edge N+4.
REQ-017 The block SHALL assert ocupado=1 exactly while in CALCULO, and 0 otherwise.
REQ-018 The block SHALL ignore operandoA and operandoB changes and banderaValida during CALCULO; the registered copies are used.
REQ-019 In LISTO, the block SHALL remain while banderaValida=1, with no new capture, even if the operands change.
REQ-020 In LISTO with banderaValida=0 at an edge, the block SHALL go to REPOSO and clear banderaListo; producto and banderaCero SHALL hold their values.
REQ-021 A new capture SHALL require banderaValida to have been 0 for at least one edge after LISTO: one multiplication per valid pulse.
REQ-022 The block SHALL update banderaCero only with producto, to (final accumulator == 0).
REQ-023 Once updated, producto and banderaCero SHALL change only on the next completion or on reset.

Reset
REQ-024 While reinicio=1 at an edge, the block SHALL set state=REPOSO, cuenta=0, accumulator=0, producto=8'h00, banderaListo=0, ocupado=0, and banderaCero=0.
REQ-025 Reset SHALL take priority over every other condition, including mid-CALCULO and LISTO; a calculation in progress is aborted with no partial result on producto.
REQ-026 After reset is released, if banderaValida=1 at the first edge in REPOSO, the block SHALL capture normally.

Verification
REQ-027 Bench scenario, 3x5: A=3, B=5, valid high at edge N -> ocupado=1 for edges N+1..N+4 region, then producto=15, banderaListo=1, and banderaCero=0 after edge N+4.
REQ-028 Bench scenario, 15x15: A=15, B=15 -> producto=225 (8'hE1) after 4 cycles, with no overflow.
REQ-029 Bench scenario, zero operand: A=0, B=9 -> producto=0, banderaCero=1, and banderaListo=1 after 4 cycles.
REQ-030 Bench scenario, operand change: change the operands to A=7, B=7 during CALCULO and hold valid in LISTO -> producto stays the first result with no recapture; drop valid -> REPOSO with banderaListo=0 and producto held.
REQ-031 Bench scenario, reset mid-calculation: reinicio=1 on the edge after capture of 6x6 -> all outputs at reset values, producto=0, and no completion appears later.
REQ-032 Bench scenario, back-to-back: 2x3 then valid low for 1 cycle, then 4x4 -> producto=6, then producto=16, each with its own banderaListo assertion.

Source files
------------

// File: rtl/subsistema_multiplicacion_if.sv
// Operand/result bundle between the operand-reading stage (master) and the
// shift-add multiplier (slave).
interface subsistema_multiplicacion_if;
    logic [3:0] operandoA;
    logic [3:0] operandoB;
    logic       banderaValida;
    logic [7:0] producto;
    logic       banderaListo;
    logic       ocupado;
    logic       banderaCero;

    modport master (
        output operandoA, operandoB, banderaValida,
        input  producto, banderaListo, ocupado, banderaCero
    );

    modport slave (
        input  operandoA, operandoB, banderaValida,
        output producto, banderaListo, ocupado, banderaCero
    );
endinterface

// File: rtl/subsistema_multiplicacion.sv
// 4x4 unsigned shift-add multiplier: one partial product per clock, four steps,
// result and zero flag held until the next completion or reset.
//
// state   | meaning
// REPOSO  | idle, waiting for banderaValida to capture operands
// CALCULO | one shift-add step per edge, cuenta selects the multiplier bit
// LISTO   | result valid; wait for banderaValida to drop before re-arming
module subsistema_multiplicacion (
    input  logic                          reloj,
    input  logic                          reinicio,
    subsistema_multiplicacion_if.slave    bus
);
    typedef enum logic [1:0] {REPOSO, CALCULO, LISTO} t_estado;

    t_estado    r_estado;
    logic [1:0] r_cuenta;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [7:0] r_acc;
    logic [7:0] r_producto;
    logic       r_listo;
    logic       r_ocupado;
    logic       r_cero;

    logic [7:0] w_sumando;
    logic [7:0] w_acc_sig;

    // 15x15 = 225 fits in 8 bits, so the accumulator needs no carry out
    assign w_sumando = r_b[r_cuenta] ? ({4'b0000, r_a} << r_cuenta) : 8'd0;
    assign w_acc_sig = r_acc + w_sumando;

    always_ff @(posedge reloj) begin
        if (reinicio) begin
            r_estado   <= REPOSO;
            r_cuenta   <= 2'd0;
            r_a        <= 4'd0;
            r_b        <= 4'd0;
            r_acc      <= 8'd0;
            r_producto <= 8'd0;
            r_listo    <= 1'b0;
            r_ocupado  <= 1'b0;
            r_cero     <= 1'b0;
        end else begin
            case (r_estado)
                REPOSO: begin
                    if (bus.banderaValida) begin
                        r_a       <= bus.operandoA;
                        r_b       <= bus.operandoB;
                        r_acc     <= 8'd0;
                        r_cuenta  <= 2'd0;
                        r_ocupado <= 1'b1;
                        r_estado  <= CALCULO;
                    end
                end
                CALCULO: begin
                    r_acc    <= w_acc_sig;
                    r_cuenta <= r_cuenta + 2'd1;
                    if (r_cuenta == 2'd3) begin
                        r_producto <= w_acc_sig;
                        r_cero     <= (w_acc_sig == 8'd0);
                        r_listo    <= 1'b1;
                        r_ocupado  <= 1'b0;
                        r_estado   <= LISTO;
                    end
                end
                LISTO: begin
                    // one multiplication per valid pulse: re-arm only once valid drops
                    if (!bus.banderaValida) begin
                        r_listo  <= 1'b0;
                        r_estado <= REPOSO;
                    end
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    assign bus.producto     = r_producto;
    assign bus.banderaListo = r_listo;
    assign bus.ocupado      = r_ocupado;
    assign bus.banderaCero  = r_cero;
endmodule
